fifo_buffer: RTL and testbench

Synchronous single-clock first-word-fall-through (show-ahead) FIFO of 2^LOG_DEPTH entries, each WIDTH bits. Serves as the request queue between a memory requester and the simulated DRAM model. Also usable as a general elastic buffer wherever the consumer needs the head entry visible before it is dequeued.

---
 rtl/fifo_buffer.sv | 60 ++++++
 tb/tb_fifo_buffer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_buffer.sv
// Single-clock show-ahead FIFO of 2**LOG_DEPTH entries; the head entry is visible on q before it is dequeued.
// Optional FIFO_OVERFLOW_CHECK_EN adds simulation-only overflow/underflow messages.
module fifo_buffer #(
    parameter int WIDTH     = 64,
    parameter int LOG_DEPTH = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wrreq,
    input  logic [WIDTH-1:0] data,
    input  logic             rdreq,
    output logic [WIDTH-1:0] q,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << LOG_DEPTH;
    localparam logic [LOG_DEPTH:0] PTR_ONE = (LOG_DEPTH+1)'(1);

    logic [WIDTH-1:0]   storage [DEPTH];
    logic [LOG_DEPTH:0] wr_ptr;
    logic [LOG_DEPTH:0] rd_ptr;
    logic               wr_accept;
    logic               rd_accept;

    // A write into a full FIFO is dropped even when a read frees a slot in the same cycle.
    assign wr_accept = wrreq && !full;
    assign rd_accept = rdreq && !empty;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_accept) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage is deliberately not reset; only the pointers define valid contents.
    always_ff @(posedge clock) begin
        if (wr_accept) storage[wr_ptr[LOG_DEPTH-1:0]] <= data;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[LOG_DEPTH-1:0] == rd_ptr[LOG_DEPTH-1:0]) &&
                   (wr_ptr[LOG_DEPTH] != rd_ptr[LOG_DEPTH]);
    assign q     = empty ? '0 : storage[rd_ptr[LOG_DEPTH-1:0]];

`ifdef FIFO_OVERFLOW_CHECK_EN
    always @(posedge clock) begin
        if (reset_n) begin
            if (wrreq && full)  $error("FIFO overflow at time %0t", $time);
            if (rdreq && empty) $error("FIFO underflow at time %0t", $time);
        end
    end
`else
`endif

endmodule

// File: tb/tb_fifo_buffer.sv
// Directed bench for fifo_buffer at WIDTH=64, LOG_DEPTH=2 (four entries).
module tb_fifo_buffer;

    logic        clock;
    logic        reset_n;
    logic        wrreq;
    logic        rdreq;
    logic [63:0] data;
    logic [63:0] q;
    logic        full;
    logic        empty;

    int pass_cnt;
    int total_cnt;

    fifo_buffer #(.WIDTH(64), .LOG_DEPTH(2)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .wrreq  (wrreq),
        .data   (data),
        .rdreq  (rdreq),
        .q      (q),
        .full   (full),
        .empty  (empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs are applied at posedge+1 and outputs sampled at the next posedge+1.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic w, input logic r, input logic [63:0] d);
        wrreq = w;
        rdreq = r;
        data  = d;
        step();
        wrreq = 1'b0;
        rdreq = 1'b0;
        data  = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        wrreq = 1'b0;
        rdreq = 1'b0;
        data  = '0;
        #12;
        total_cnt++;
        if (empty !== 1'b1 || full !== 1'b0 || q !== 64'h0)
            $display("FAIL reset_hold: empty=%b full=%b q=%h, required 1 0 0", empty, full, q);
        else pass_cnt++;
        reset_n = 1'b1;
        step();
        step();
        total_cnt++;
        if (empty !== 1'b1 || full !== 1'b0 || q !== 64'h0)
            $display("FAIL reset_idle: empty=%b full=%b q=%h, required 1 0 0", empty, full, q);
        else pass_cnt++;
    endtask

    task automatic test_fill_drain();
        logic [63:0] vals [4];
        vals[0] = 64'h11; vals[1] = 64'h22; vals[2] = 64'h33; vals[3] = 64'h44;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, vals[i]);
            total_cnt++;
            if (empty !== 1'b0 || q !== 64'h11 || full !== (i == 3))
                $display("FAIL fill_%0d: empty=%b full=%b q=%h, required 0 %b 11", i, empty, full, q, (i == 3));
            else pass_cnt++;
        end
        drive(1'b1, 1'b0, 64'h55);
        total_cnt++;
        if (full !== 1'b1 || q !== 64'h11)
            $display("FAIL overflow_drop: full=%b q=%h, required 1 11", full, q);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (q !== vals[i])
                $display("FAIL drain_%0d: q=%h, required %h", i, q, vals[i]);
            else pass_cnt++;
            drive(1'b0, 1'b1, 64'h0);
        end
        total_cnt++;
        if (empty !== 1'b1 || full !== 1'b0 || q !== 64'h0)
            $display("FAIL drain_end: empty=%b full=%b q=%h, required 1 0 0", empty, full, q);
        else pass_cnt++;
        drive(1'b0, 1'b1, 64'h0);
        total_cnt++;
        if (empty !== 1'b1 || q !== 64'h0)
            $display("FAIL underflow_ignored: empty=%b q=%h, required 1 0", empty, q);
        else pass_cnt++;
    endtask

    task automatic test_simul_empty();
        drive(1'b1, 1'b1, 64'hAA);
        total_cnt++;
        if (empty !== 1'b0 || q !== 64'hAA)
            $display("FAIL simul_empty: empty=%b q=%h, required 0 aa", empty, q);
        else pass_cnt++;
        drive(1'b0, 1'b1, 64'h0);
        total_cnt++;
        if (empty !== 1'b1)
            $display("FAIL simul_empty_drain: empty=%b, required 1", empty);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b0, 64'h1);
        drive(1'b1, 1'b0, 64'h2);
        drive(1'b1, 1'b1, 64'h3);
        total_cnt++;
        if (q !== 64'h2 || empty !== 1'b0 || full !== 1'b0)
            $display("FAIL b2b_rw: q=%h empty=%b full=%b, required 2 0 0", q, empty, full);
        else pass_cnt++;
        drive(1'b0, 1'b1, 64'h0);
        total_cnt++;
        if (q !== 64'h3 || empty !== 1'b0)
            $display("FAIL b2b_second: q=%h empty=%b, required 3 0", q, empty);
        else pass_cnt++;
        drive(1'b0, 1'b1, 64'h0);
        total_cnt++;
        if (empty !== 1'b1 || q !== 64'h0)
            $display("FAIL b2b_occupancy: empty=%b q=%h, required 1 0", empty, q);
        else pass_cnt++;
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 64'hA0 + 64'(i));
        total_cnt++;
        if (full !== 1'b1)
            $display("FAIL full_rw_pre: full=%b, required 1", full);
        else pass_cnt++;
        drive(1'b1, 1'b1, 64'h99);
        total_cnt++;
        if (full !== 1'b0 || q !== 64'hA1)
            $display("FAIL full_rw: full=%b q=%h, required 0 a1", full, q);
        else pass_cnt++;
        drive(1'b0, 1'b1, 64'h0);
        drive(1'b0, 1'b1, 64'h0);
        total_cnt++;
        if (q !== 64'hA3)
            $display("FAIL full_rw_last: q=%h, required a3", q);
        else pass_cnt++;
        drive(1'b0, 1'b1, 64'h0);
        total_cnt++;
        if (empty !== 1'b1 || q !== 64'h0)
            $display("FAIL full_rw_dropped: empty=%b q=%h, required 1 0", empty, q);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        int errs;
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 64'hC000 + 64'(i));
            if (q !== 64'hC000 + 64'(i) || empty !== 1'b0 || full !== 1'b0) begin
                $display("FAIL wrap_write_%0d: q=%h empty=%b full=%b, required %h 0 0", i, q, empty, full, 64'hC000 + 64'(i));
                errs++;
            end
            drive(1'b0, 1'b1, 64'h0);
            if (empty !== 1'b1 || full !== 1'b0) begin
                $display("FAIL wrap_read_%0d: empty=%b full=%b, required 1 0", i, empty, full);
                errs++;
            end
        end
        total_cnt++;
        if (errs != 0) $display("FAIL wrap: %0d errors, required 0", errs);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b0, 64'h5A);
        drive(1'b1, 1'b0, 64'h5B);
        #3;
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if (empty !== 1'b1 || full !== 1'b0 || q !== 64'h0)
            $display("FAIL async_reset: empty=%b full=%b q=%h, required 1 0 0", empty, full, q);
        else pass_cnt++;
        #2;
        reset_n = 1'b1;
        step();
        drive(1'b1, 1'b0, 64'h77);
        total_cnt++;
        if (q !== 64'h77 || empty !== 1'b0)
            $display("FAIL post_reset_head: q=%h empty=%b, required 77 0", q, empty);
        else pass_cnt++;
        drive(1'b0, 1'b1, 64'h0);
        total_cnt++;
        if (empty !== 1'b1)
            $display("FAIL post_reset_discard: empty=%b, required 1", empty);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_fill_drain();
        test_simul_empty();
        test_back_to_back();
        test_full_rw();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
